dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_if.sv | 24 ++
 rtl/dmem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/response bundle between a requester and dmem_ctrl
interface dmem_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_mode;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_mode, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_mode, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressed data memory with b/h/w loads and stores, word-crossing split
module dmem_ctrl #(
    parameter int ADDR_W           = 10,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic       clk,
    input logic       rst,
    dmem_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, SPLIT} state_t;

    logic [7:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [3:0][7:0]   bytes_q, bytes_d;

    logic [2:0]        req_size;
    logic              req_sign;
    logic              mode_bad;
    logic [1:0]        align_mask;
    logic [ADDR_W:0]   end_addr;
    logic              req_err;

    always_comb begin
        req_size   = 3'd1;
        req_sign   = 1'b0;
        mode_bad   = 1'b0;
        align_mask = 2'b00;
        case (bus.req_mode)
            3'b000: begin req_size = 3'd1; req_sign = 1'b1; end
            3'b001: begin req_size = 3'd2; req_sign = 1'b1; align_mask = 2'b01; end
            3'b010: begin req_size = 3'd4; align_mask = 2'b11; end
            3'b100: req_size = 3'd1;
            3'b101: begin req_size = 3'd2; align_mask = 2'b01; end
            default: mode_bad = 1'b1;
        endcase
        // carry out of the last byte address means the access would wrap
        end_addr = {1'b0, bus.req_addr} + (ADDR_W+1)'(req_size - 3'd1);
        req_err  = mode_bad
                 | (bus.req_we & bus.req_mode[2])
                 | end_addr[ADDR_W]
                 | (!ALLOW_MISALIGNED && ((bus.req_addr[1:0] & align_mask) != 2'b00));
    end

    logic              in_split;
    logic              accept;
    logic              go;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_we;
    logic [31:0]       cur_wdata;
    logic [2:0]        cur_size;
    logic              cur_sign;
    logic [2:0]        lo_cnt;
    logic              crossing;
    logic [3:0]        act;
    logic [3:0][ADDR_W-1:0] baddr;
    logic [3:0][7:0]   asm_bytes;
    logic [3:0]        mem_we;
    logic [3:0][7:0]   mem_wbyte;
    logic [31:0]       ext_data;

    always_comb begin
        in_split  = (state_q == SPLIT);
        accept    = bus.req_valid && (state_q == IDLE);
        go        = in_split || (accept && !req_err);
        cur_addr  = in_split ? addr_q  : bus.req_addr;
        cur_we    = in_split ? we_q    : bus.req_we;
        cur_wdata = in_split ? wdata_q : bus.req_wdata;
        cur_size  = in_split ? size_q  : req_size;
        cur_sign  = in_split ? sign_q  : req_sign;
        // bytes of the access that fall in the first (lower) word
        lo_cnt    = 3'd4 - {1'b0, cur_addr[1:0]};
        crossing  = cur_size > lo_cnt;
        for (int k = 0; k < 4; k++) begin
            act[k]       = (3'(k) < cur_size) && (in_split ? (3'(k) >= lo_cnt) : (3'(k) < lo_cnt));
            baddr[k]     = cur_addr + ADDR_W'(k);
            asm_bytes[k] = act[k] ? mem[baddr[k]] : bytes_q[k];
            mem_we[k]    = go && cur_we && act[k] && !rst;
            mem_wbyte[k] = cur_wdata[8*k +: 8];
        end
        case (cur_size)
            3'd1:    ext_data = {{24{cur_sign & asm_bytes[0][7]}}, asm_bytes[0]};
            3'd2:    ext_data = {{16{cur_sign & asm_bytes[1][7]}}, asm_bytes[1], asm_bytes[0]};
            default: ext_data = asm_bytes;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        sign_d       = sign_q;
        bytes_d      = bytes_q;
        if (in_split) begin
            state_d      = IDLE;
            req_ready_d  = 1'b1;
            resp_valid_d = 1'b1;
            resp_rdata_d = cur_we ? 32'd0 : ext_data;
        end else if (accept) begin
            if (req_err) begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
            end else if (crossing) begin
                state_d     = SPLIT;
                req_ready_d = 1'b0;
                addr_d      = bus.req_addr;
                we_d        = bus.req_we;
                wdata_d     = bus.req_wdata;
                size_d      = req_size;
                sign_d      = req_sign;
                bytes_d     = asm_bytes;
            end else begin
                resp_valid_d = 1'b1;
                resp_rdata_d = cur_we ? 32'd0 : ext_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= 32'd0;
            size_q       <= 3'd1;
            sign_q       <= 1'b0;
            bytes_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            bytes_q      <= bytes_d;
        end
    end

    // storage is deliberately not reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we[k]) mem[baddr[k]] <= mem_wbyte[k];
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed bench for dmem_ctrl, misaligned-split and strict-alignment instances
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dmem_ctrl_if #(.ADDR_W(10)) if_a ();
    dmem_ctrl_if #(.ADDR_W(10)) if_b ();

    dmem_ctrl #(.ADDR_W(10), .ALLOW_MISALIGNED(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    dmem_ctrl #(.ADDR_W(10), .ALLOW_MISALIGNED(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    localparam logic [2:0] M_B = 3'b000, M_H = 3'b001, M_W = 3'b010, M_BU = 3'b100, M_HU = 3'b101;

    task automatic drive(input bit sel, input logic v, input logic we, input logic [2:0] mode,
                         input logic [9:0] addr, input logic [31:0] wdata);
        if (sel) begin
            if_b.req_valid = v; if_b.req_we = we; if_b.req_mode = mode;
            if_b.req_addr = addr; if_b.req_wdata = wdata;
        end else begin
            if_a.req_valid = v; if_a.req_we = we; if_a.req_mode = mode;
            if_a.req_addr = addr; if_a.req_wdata = wdata;
        end
    endtask

    // issues one request, returns response fields, latency in edges and req_ready right after accept
    task automatic req(input bit sel, input logic we, input logic [2:0] mode, input logic [9:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                       output int lat, output logic rdy_mid);
        logic rv;
        @(posedge clk); #1;
        drive(sel, 1'b1, we, mode, addr, wdata);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 3'b000, 10'h0, 32'h0);
        lat = 1;
        rdy_mid = sel ? if_b.req_ready : if_a.req_ready;
        rv = sel ? if_b.resp_valid : if_a.resp_valid;
        while (!rv && lat < 6) begin
            @(posedge clk); #1;
            lat++;
            rv = sel ? if_b.resp_valid : if_a.resp_valid;
        end
        rdata = sel ? if_b.resp_rdata : if_a.resp_rdata;
        err   = sel ? if_b.resp_err : if_a.resp_err;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 10'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 10'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        total++; if (if_a.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", if_a.resp_valid); end
        total++; if (if_a.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", if_a.resp_rdata); end
        total++; if (if_a.resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", if_a.resp_err); end
        total++; if (if_a.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", if_a.req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_aligned();
        logic [31:0] d; logic e; int l; logic r;
        req(1'b0, 1'b1, M_W, 10'h004, 32'h11223344, d, e, l, r);
        total++; if (l !== 1 || e !== 1'b0 || d !== 32'h0) begin bad++; $display("FAIL sw_4 lat=%0d err=%b rdata=%h want 1/0/0", l, e, d); end
        req(1'b0, 1'b0, M_B, 10'h007, 32'h0, d, e, l, r);
        total++; if (l !== 1 || e !== 1'b0 || d !== 32'h00000011) begin bad++; $display("FAIL lb_7 lat=%0d err=%b rdata=%h want 1/0/00000011", l, e, d); end
        req(1'b0, 1'b0, M_BU, 10'h004, 32'h0, d, e, l, r);
        total++; if (l !== 1 || e !== 1'b0 || d !== 32'h00000044) begin bad++; $display("FAIL lbu_4 lat=%0d err=%b rdata=%h want 1/0/00000044", l, e, d); end
        req(1'b0, 1'b0, M_H, 10'h006, 32'h0, d, e, l, r);
        total++; if (l !== 1 || e !== 1'b0 || d !== 32'h00001122) begin bad++; $display("FAIL lh_6 lat=%0d err=%b rdata=%h want 1/0/00001122", l, e, d); end
        @(posedge clk); #1;
        total++; if (if_a.resp_valid !== 1'b0) begin bad++; $display("FAIL resp_pulse got %b want 0", if_a.resp_valid); end
        req(1'b0, 1'b1, M_B, 10'h00C, 32'h00000080, d, e, l, r);
        req(1'b0, 1'b0, M_B, 10'h00C, 32'h0, d, e, l, r);
        total++; if (d !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_sext got %h want ffffff80", d); end
        req(1'b0, 1'b0, M_HU, 10'h006, 32'h0, d, e, l, r);
        total++; if (d !== 32'h00001122) begin bad++; $display("FAIL lhu_6 got %h want 00001122", d); end
    endtask

    task automatic test_split();
        logic [31:0] d; logic e; int l; logic r;
        req(1'b0, 1'b1, M_W, 10'h006, 32'hDEADBEEF, d, e, l, r);
        total++; if (r !== 1'b0) begin bad++; $display("FAIL split_ready got %b want 0", r); end
        total++; if (l !== 2 || e !== 1'b0 || d !== 32'h0) begin bad++; $display("FAIL sw_6 lat=%0d err=%b rdata=%h want 2/0/0", l, e, d); end
        total++; if (if_a.req_ready !== 1'b1) begin bad++; $display("FAIL split_ready_back got %b want 1", if_a.req_ready); end
        req(1'b0, 1'b0, M_W, 10'h006, 32'h0, d, e, l, r);
        total++; if (l !== 2 || e !== 1'b0 || d !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_6 lat=%0d err=%b rdata=%h want 2/0/deadbeef", l, e, d); end
        req(1'b0, 1'b0, M_H, 10'h005, 32'h0, d, e, l, r);
        total++; if (l !== 1 || e !== 1'b0 || d !== 32'hFFFFEF33) begin bad++; $display("FAIL lh_5 lat=%0d err=%b rdata=%h want 1/0/ffffef33", l, e, d); end
        req(1'b0, 1'b0, M_HU, 10'h007, 32'h0, d, e, l, r);
        total++; if (l !== 2 || d !== 32'h0000ADBE) begin bad++; $display("FAIL lhu_7 lat=%0d rdata=%h want 2/0000adbe", l, d); end
    endtask

    task automatic test_range();
        logic [31:0] d; logic e; int l; logic r;
        req(1'b0, 1'b1, M_B, 10'h3FE, 32'h0000005A, d, e, l, r);
        req(1'b0, 1'b1, M_B, 10'h3FF, 32'h000000A5, d, e, l, r);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL sb_3ff err got %b want 0", e); end
        req(1'b0, 1'b0, M_W, 10'h3FE, 32'h0, d, e, l, r);
        total++; if (l !== 1 || e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL lw_3fe lat=%0d err=%b rdata=%h want 1/1/0", l, e, d); end
        req(1'b0, 1'b1, M_W, 10'h3FE, 32'hFFFFFFFF, d, e, l, r);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL sw_3fe err got %b want 1", e); end
        req(1'b0, 1'b0, M_H, 10'h3FF, 32'h0, d, e, l, r);
        total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL lh_3ff err=%b rdata=%h want 1/0", e, d); end
        req(1'b0, 1'b0, M_HU, 10'h3FE, 32'h0, d, e, l, r);
        total++; if (e !== 1'b0 || d !== 32'h0000A55A) begin bad++; $display("FAIL lhu_3fe err=%b rdata=%h want 0/0000a55a", e, d); end
    endtask

    task automatic test_illegal();
        logic [31:0] d; logic e; int l; logic r;
        req(1'b0, 1'b0, 3'b011, 10'h004, 32'h0, d, e, l, r);
        total++; if (l !== 1 || e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL mode011 lat=%0d err=%b rdata=%h want 1/1/0", l, e, d); end
        req(1'b0, 1'b1, M_HU, 10'h004, 32'h00009999, d, e, l, r);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL sh_hu err got %b want 1", e); end
        req(1'b0, 1'b1, 3'b111, 10'h004, 32'h77777777, d, e, l, r);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL sw_111 err got %b want 1", e); end
        req(1'b0, 1'b0, M_W, 10'h004, 32'h0, d, e, l, r);
        total++; if (e !== 1'b0 || d !== 32'hBEEF3344) begin bad++; $display("FAIL lw_4_after err=%b rdata=%h want 0/beef3344", e, d); end
    endtask

    task automatic test_nomisalign();
        logic [31:0] d; logic e; int l; logic r;
        req(1'b1, 1'b1, M_B, 10'h001, 32'h00000077, d, e, l, r);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL b_sb_1 err got %b want 0", e); end
        req(1'b1, 1'b1, M_H, 10'h001, 32'h0000ABCD, d, e, l, r);
        total++; if (l !== 1 || e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL b_sh_1 lat=%0d err=%b rdata=%h want 1/1/0", l, e, d); end
        req(1'b1, 1'b0, M_BU, 10'h001, 32'h0, d, e, l, r);
        total++; if (e !== 1'b0 || d !== 32'h00000077) begin bad++; $display("FAIL b_lbu_1 err=%b rdata=%h want 0/00000077", e, d); end
        req(1'b1, 1'b0, M_W, 10'h002, 32'h0, d, e, l, r);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL b_lw_2 err got %b want 1", e); end
        req(1'b1, 1'b1, M_H, 10'h002, 32'h00008001, d, e, l, r);
        req(1'b1, 1'b0, M_H, 10'h002, 32'h0, d, e, l, r);
        total++; if (l !== 1 || e !== 1'b0 || d !== 32'hFFFF8001) begin bad++; $display("FAIL b_lh_2 lat=%0d err=%b rdata=%h want 1/0/ffff8001", l, e, d); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, M_W, 10'h010, 32'hCAFEF00D);
        @(posedge clk); #1;
        total++; if (if_a.resp_valid !== 1'b1) begin bad++; $display("FAIL b2b_sw_valid got %b want 1", if_a.resp_valid); end
        drive(1'b0, 1'b1, 1'b0, M_W, 10'h010, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 10'h0, 32'h0);
        total++; if (if_a.resp_valid !== 1'b1 || if_a.resp_rdata !== 32'hCAFEF00D) begin
            bad++; $display("FAIL b2b_lw valid=%b rdata=%h want 1/cafef00d", if_a.resp_valid, if_a.resp_rdata); end
        @(posedge clk); #1;
        total++; if (if_a.resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got %b want 0", if_a.resp_valid); end
    endtask

    task automatic test_split_reset();
        logic [31:0] d; logic e; int l; logic r; int seen;
        req(1'b0, 1'b1, M_W, 10'h01C, 32'h0, d, e, l, r);
        req(1'b0, 1'b1, M_W, 10'h020, 32'h0, d, e, l, r);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, M_W, 10'h01E, 32'h01020304);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 10'h0, 32'h0);
        total++; if (if_a.req_ready !== 1'b0) begin bad++; $display("FAIL rs_in_split ready got %b want 0", if_a.req_ready); end
        rst = 1'b1;
        #1;
        total++; if (if_a.req_ready !== 1'b1) begin bad++; $display("FAIL rs_ready_now got %b want 1", if_a.req_ready); end
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (if_a.resp_valid !== 1'b0) seen++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (if_a.resp_valid !== 1'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rs_no_resp got %0d pulses want 0", seen); end
        req(1'b0, 1'b0, M_W, 10'h01C, 32'h0, d, e, l, r);
        total++; if (e !== 1'b0 || d !== 32'h03040000) begin bad++; $display("FAIL rs_lower_kept err=%b rdata=%h want 0/03040000", e, d); end
        req(1'b0, 1'b0, M_W, 10'h020, 32'h0, d, e, l, r);
        total++; if (e !== 1'b0 || d !== 32'h00000000) begin bad++; $display("FAIL rs_upper_dropped err=%b rdata=%h want 0/00000000", e, d); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_split();
        test_range();
        test_illegal();
        test_nomisalign();
        test_back_to_back();
        test_split_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
